// File: rtl/dotproduct_sequencer.sv
// Control FSM that runs one dot-product job on the dotProduct datapath:
// optional memory clear and file load, index/PE reset, compute, then a step-count check.
module dotproduct_sequencer #(
   parameter int Nums_Data_in_bits       = 4,
   parameter int Nums_Data               = 1 << Nums_Data_in_bits,
   parameter int Nums_Pipeline_Stages    = 4,
   parameter int Pipeline_Tail           = Nums_Pipeline_Stages - 1,
   parameter int Total_Computation_Steps = Nums_Data + Pipeline_Tail
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         start,
   input  logic                         load_en,
   input  logic                         accumulate,
   input  logic                         abort,
   input  logic                         file_valid,
   output logic                         file_ready,
   input  logic [Nums_Data_in_bits:0]   dp_state,
   output logic                         Mem_reset,
   output logic                         Comp_reset,
   output logic                         Mem_Index_reset,
   output logic                         PE_reset,
   output logic                         Computing,
   output logic                         load_old_output,
   output logic                         load_from_file,
   output logic                         busy,
   output logic                         done,
   output logic                         error,
   output logic [Nums_Data_in_bits:0]   load_count
);

   localparam int CW     = Nums_Data_in_bits + 1;
   localparam int STEP_W = $clog2(Total_Computation_Steps + 1);

   localparam logic [CW-1:0]     NUMS_DATA_C = CW'(Nums_Data);
   localparam logic [CW-1:0]     EXP_STATE   = CW'(Total_Computation_Steps);
   localparam logic [STEP_W-1:0] LAST_STEP   = STEP_W'(Total_Computation_Steps - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_LOAD,
      S_INIT,
      S_COMPUTE,
      S_CHECK,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [CW-1:0]     load_count_q, load_count_d;
   logic              acc_q, acc_d;
   logic              load_q, load_d;
   logic              error_q, error_d;
   logic              accept_word;

   // A word is consumed only in LOAD, and never in a cycle that is being aborted.
   assign accept_word = (state_q == S_LOAD) && load_q && file_valid && !abort;

   always_comb begin
      // NOTE: every next-state signal takes its hold value first, so no path leaves it unassigned (no latch).
      state_d      = state_q;
      step_d       = step_q;
      load_count_d = load_count_q;
      acc_d        = acc_q;
      load_d       = load_q;
      error_d      = error_q;

      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  acc_d        = accumulate;
                  load_d       = load_en;
                  error_d      = 1'b0;
                  load_count_d = '0;
                  state_d      = load_en ? S_CLEAR : S_INIT;
               end
            end
            S_CLEAR: state_d = S_LOAD;
            S_LOAD: begin
               if (accept_word) begin
                  if (load_count_q != NUMS_DATA_C) load_count_d = load_count_q + 1'b1;
                  if (load_count_q == NUMS_DATA_C - 1'b1) state_d = S_INIT;
               end
            end
            S_INIT: begin
               step_d  = '0;
               state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
               if (step_q == LAST_STEP) state_d = S_CHECK;
               else                     step_d  = step_q + 1'b1;
            end
            S_CHECK: begin
               // The datapath must have stepped exactly once per Computing cycle.
               if (dp_state != EXP_STATE) error_d = 1'b1;
               state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         step_q       <= '0;
         load_count_q <= '0;
         acc_q        <= 1'b0;
         load_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
         state_q      <= state_d;
         step_q       <= step_d;
         load_count_q <= load_count_d;
         acc_q        <= acc_d;
         load_q       <= load_d;
         error_q      <= error_d;
      end
   end

   always_comb begin
      Mem_reset       = 1'b0;
      Comp_reset      = 1'b0;
      Mem_Index_reset = 1'b0;
      PE_reset        = 1'b0;
      Computing       = 1'b0;
      load_old_output = 1'b0;
      done            = 1'b0;
      case (state_q)
         S_CLEAR: begin
            Mem_reset       = 1'b1;
            Mem_Index_reset = 1'b1;
         end
         S_INIT: begin
            Comp_reset      = 1'b1;
            PE_reset        = 1'b1;
            Mem_Index_reset = 1'b1;
         end
         S_COMPUTE: begin
            Computing       = !abort;
            load_old_output = acc_q;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   assign file_ready     = accept_word;
   assign load_from_file = accept_word;
   assign busy           = (state_q != S_IDLE);
   assign error          = error_q;
   assign load_count     = load_count_q;

endmodule

// File: tb/tb_dotproduct_sequencer.sv
// Self-checking bench for dotproduct_sequencer: per-job expectations are queued at start
// and compared when the done pulse arrives; abort and async reset are checked inline.
`timescale 1ns/1ps
module tb_dotproduct_sequencer;

   localparam int DW    = 4;
   localparam int ND    = 16;
   localparam int TOTAL = 19;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0, load_en = 1'b0, accumulate = 1'b0, abort = 1'b0, file_valid = 1'b0;
   logic [DW:0]   dp_state = 5'd19;
   logic          file_ready, Mem_reset, Comp_reset, Mem_Index_reset, PE_reset;
   logic          Computing, load_old_output, load_from_file, busy, done, error;
   logic [DW:0]   load_count;

   always #5 clk = ~clk;

   dotproduct_sequencer dut (
      .clk(clk), .reset_n(reset_n), .start(start), .load_en(load_en), .accumulate(accumulate),
      .abort(abort), .file_valid(file_valid), .file_ready(file_ready), .dp_state(dp_state),
      .Mem_reset(Mem_reset), .Comp_reset(Comp_reset), .Mem_Index_reset(Mem_Index_reset),
      .PE_reset(PE_reset), .Computing(Computing), .load_old_output(load_old_output),
      .load_from_file(load_from_file), .busy(busy), .done(done), .error(error),
      .load_count(load_count)
   );

   typedef struct {
      int comp_cycles;
      int words;
      int mem_resets;
      bit err;
   } job_t;

   job_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic cur_acc  = 1'b0;

   // Negedge monitor: cumulative event counters and protocol-violation counters.
   int   cyc = 0, comp_cnt = 0, mem_rst_cnt = 0, init_cnt = 0, done_cnt = 0, word_cnt = 0;
   int   ready_bad = 0, acc_bad = 0, overlap_bad = 0, comp_rise_cyc = 0, done_cyc = 0;
   logic prev_comp = 1'b0;

   always @(negedge clk) begin
      cyc       <= cyc + 1;
      prev_comp <= Computing;
      if (Computing) comp_cnt <= comp_cnt + 1;
      if (Computing && !prev_comp) comp_rise_cyc <= cyc;
      if (Mem_reset) mem_rst_cnt <= mem_rst_cnt + 1;
      if (Comp_reset) init_cnt <= init_cnt + 1;
      if (done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
      if (file_ready) word_cnt <= word_cnt + 1;
      if ((file_ready && !file_valid) || (file_ready !== load_from_file)) ready_bad <= ready_bad + 1;
      if ((Computing && (load_old_output !== cur_acc)) || (load_old_output && !Computing && !abort))
         acc_bad <= acc_bad + 1;
      if ((Mem_reset && Computing) || (Mem_reset && Comp_reset)) overlap_bad <= overlap_bad + 1;
   end

   function automatic logic pat(input int mode, input int c);
      if (mode == 0) return 1'b1;
      return ((c % 4) == 0) || ((c % 4) == 3);
   endfunction

   function automatic logic [10:0] out_vec();
      return {file_ready, Mem_reset, Comp_reset, Mem_Index_reset, PE_reset, Computing,
              load_old_output, load_from_file, busy, done, error};
   endfunction

   task automatic test_reset();
      #3;
      n_checks++;
      if (out_vec() !== 11'b0 || load_count !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b/%0d, want all 0", out_vec(), load_count);
      end
      start = 1'b1;
      load_en = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_holds_idle: busy=%b, want 0", busy);
      end
      start = 1'b0;
      load_en = 1'b0;
      #2 reset_n = 1'b1;
   endtask

   task automatic run_job(input bit le, input bit ac, input int vmode, input logic [DW:0] dps,
                          input bit exp_err, input string name);
      job_t e;
      int   s_comp, s_mem, s_init, s_done, s_words, s_rbad, s_abad, s_obad;
      int   exp_lc = 0, lc_err = 0;
      bit   seen = 1'b0;
      dp_state = dps;
      @(posedge clk); #1;
      start = 1'b1; load_en = le; accumulate = ac; cur_acc = ac;
      e.comp_cycles = TOTAL;
      e.words       = le ? ND : 0;
      e.mem_resets  = le ? 1 : 0;
      e.err         = exp_err;
      sb_q.push_back(e);
      s_comp = comp_cnt; s_mem = mem_rst_cnt; s_init = init_cnt; s_done = done_cnt;
      s_words = word_cnt; s_rbad = ready_bad; s_abad = acc_bad; s_obad = overlap_bad;
      @(posedge clk); #1;
      start = 1'b0; load_en = 1'b0; accumulate = 1'b0;
      file_valid = pat(vmode, 0);
      @(negedge clk);
      n_checks++;
      if ((le ? Mem_reset : Comp_reset) !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_first_state: Mem_reset=%b Comp_reset=%b busy=%b, want %s", name,
                  Mem_reset, Comp_reset, busy, le ? "CLEAR" : "INIT");
      end
      n_checks++;
      if (error !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_error_cleared: error=%b, want 0", name, error);
      end
      for (int c = 1; c < 400 && !seen; c++) begin
         if (load_count !== exp_lc[DW:0]) lc_err++;
         if (file_ready) exp_lc++;
         if (done) seen = 1'b1;
         else begin
            @(posedge clk); #1;
            file_valid = pat(vmode, c);
            @(negedge clk);
         end
      end
      file_valid = 1'b0;
      e = sb_q.pop_front();
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: no done within 400 cycles", name);
         return;
      end
      n_checks++;
      if (error !== e.err) begin
         n_fail++;
         $display("FAIL %s_error_at_done: got %b, want %b", name, error, e.err);
      end
      n_checks++;
      if (load_count !== e.words[DW:0]) begin
         n_fail++;
         $display("FAIL %s_load_count: got %0d, want %0d", name, load_count, e.words);
      end
      @(negedge clk); #1;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || error !== e.err) begin
         n_fail++;
         $display("FAIL %s_idle_after: busy=%b done=%b error=%b, want 0 0 %b", name, busy, done, error, e.err);
      end
      n_checks++;
      if (comp_cnt - s_comp != e.comp_cycles) begin
         n_fail++;
         $display("FAIL %s_computing_cycles: got %0d, want %0d", name, comp_cnt - s_comp, e.comp_cycles);
      end
      n_checks++;
      if (word_cnt - s_words != e.words || mem_rst_cnt - s_mem != e.mem_resets) begin
         n_fail++;
         $display("FAIL %s_load_phase: words=%0d mem_resets=%0d, want %0d %0d", name,
                  word_cnt - s_words, mem_rst_cnt - s_mem, e.words, e.mem_resets);
      end
      n_checks++;
      if (init_cnt - s_init != 1 || done_cnt - s_done != 1) begin
         n_fail++;
         $display("FAIL %s_strobes: init=%0d done=%0d, want 1 1", name, init_cnt - s_init, done_cnt - s_done);
      end
      n_checks++;
      if (done_cyc - comp_rise_cyc != TOTAL + 1) begin
         n_fail++;
         $display("FAIL %s_done_latency: got %0d, want %0d", name, done_cyc - comp_rise_cyc, TOTAL + 1);
      end
      n_checks++;
      if (lc_err != 0) begin
         n_fail++;
         $display("FAIL %s_load_count_track: %0d cycles off, want 0", name, lc_err);
      end
      n_checks++;
      if (ready_bad != s_rbad || acc_bad != s_abad || overlap_bad != s_obad) begin
         n_fail++;
         $display("FAIL %s_protocol: ready_bad=%0d acc_bad=%0d overlap=%0d, want 0", name,
                  ready_bad - s_rbad, acc_bad - s_abad, overlap_bad - s_obad);
      end
   endtask

   task automatic test_load_job();
      run_job(1'b1, 1'b0, 0, 5'd19, 1'b0, "load");
   endtask

   task automatic test_accumulate_job();
      run_job(1'b0, 1'b1, 0, 5'd19, 1'b0, "accum");
   endtask

   task automatic test_load_stall();
      run_job(1'b1, 1'b1, 1, 5'd19, 1'b0, "stall");
   endtask

   task automatic test_check_mismatch();
      run_job(1'b0, 1'b0, 0, 5'd5, 1'b1, "mismatch");
      run_job(1'b0, 1'b0, 0, 5'd19, 1'b0, "after_mismatch");
   endtask

   task automatic test_abort();
      int s_comp, s_mem, s_done, n = 0;
      dp_state = 5'd19;
      @(posedge clk); #1;
      start = 1'b1; load_en = 1'b0; accumulate = 1'b0; cur_acc = 1'b0;
      s_comp = comp_cnt; s_mem = mem_rst_cnt; s_done = done_cnt;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < 50 && n < 3; c++) begin
         @(negedge clk);
         if (Computing) n++;
      end
      @(posedge clk); #1;
      start = 1'b1; load_en = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; load_en = 1'b0;
      @(negedge clk);
      n_checks++;
      if (Computing !== 1'b1 || Mem_reset !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_busy_start_ignored: Computing=%b Mem_reset=%b, want 1 0", Computing, Mem_reset);
      end
      @(posedge clk);
      @(posedge clk); #1;
      abort = 1'b1;
      #1;
      n_checks++;
      if (Computing !== 1'b0 || file_ready !== 1'b0 || load_from_file !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_same_cycle: Computing=%b file_ready=%b busy=%b, want 0 0 1",
                  Computing, file_ready, busy);
      end
      @(posedge clk); #1;
      abort = 1'b0;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_idle_next: busy=%b, want 0", busy);
      end
      repeat (25) @(negedge clk);
      #1;
      n_checks++;
      if (done_cnt != s_done || mem_rst_cnt != s_mem || comp_cnt - s_comp != 6) begin
         n_fail++;
         $display("FAIL abort_aftermath: done=%0d mem_resets=%0d computing=%0d, want 0 0 6",
                  done_cnt - s_done, mem_rst_cnt - s_mem, comp_cnt - s_comp);
      end
   endtask

   task automatic test_async_reset();
      bit reached = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; load_en = 1'b1; accumulate = 1'b1; cur_acc = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; load_en = 1'b0; accumulate = 1'b0;
      file_valid = 1'b1;
      for (int c = 0; c < 50 && !reached; c++) begin
         @(negedge clk);
         if (load_count == 5'd9) reached = 1'b1;
      end
      n_checks++;
      if (!reached) begin
         n_fail++;
         $display("FAIL async_reach_9: load_count=%0d, want 9", load_count);
      end
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if (out_vec() !== 11'b0 || load_count !== '0) begin
         n_fail++;
         $display("FAIL async_reset_outputs: got %b/%0d, want all 0", out_vec(), load_count);
      end
      file_valid = 1'b0;
      @(negedge clk);
      #2 reset_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || load_count !== '0) begin
         n_fail++;
         $display("FAIL async_after_release: busy=%b load_count=%0d, want 0 0", busy, load_count);
      end
   endtask

   initial begin
      test_reset();
      test_load_job();
      test_accumulate_job();
      test_load_stall();
      test_check_mismatch();
      test_abort();
      test_async_reset();
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drained: %0d entries left, want 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
